// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_pkg
// Description : Shared types and constants for the accumulator sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package accum_pkg;

    localparam int c_DEF_WIDTH = 8;
    localparam int c_DEF_CNT_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way combinational round-robin arbiter; ties go to the
//               requester that was not granted last.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import accum_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic enable,
    output logic grant,
    output logic gnt_valid
);

    logic w_tie;

    assign w_tie     = valid0 & valid1;
    assign grant     = w_tie ? ~last_grant : (valid1 ? REQ1 : REQ0);
    assign gnt_valid = enable & (valid0 | valid1);

endmodule
`default_nettype wire

// File: rtl/accum_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : accum_seq_ctrl
// Description : Sequences two arbitrated requesters into an 8-bit accumulator.
//               Optional macro ACCUM_SAT_EN saturates acc on carry-out.
// Revision    : 1.0  initial release
// ============================================================================
module accum_seq_ctrl
    import accum_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int CNT_W = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             valid0,
    input  logic [WIDTH-1:0] data0,
    output logic             ready0,
    input  logic             valid1,
    input  logic [WIDTH-1:0] data1,
    output logic             ready1,
    output logic [WIDTH-1:0] acc,
    output logic             overflow,
    output logic [CNT_W-1:0] op_count,
    output logic             busy,
    output logic             done,
    output logic             done_id
);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_operand;
    logic               r_id;
    logic               r_last_grant;
    logic [WIDTH-1:0]   r_acc;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_count;

    logic               w_grant;
    logic               w_handshake;
    logic               w_arb_en;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_acc_next;

    assign w_arb_en = (r_state == ST_IDLE) & ~clear;

    rr_arbiter2 u_arb (
        .valid0     (valid0),
        .valid1     (valid1),
        .last_grant (r_last_grant),
        .enable     (w_arb_en),
        .grant      (w_grant),
        .gnt_valid  (w_handshake)
    );

    assign ready0 = w_handshake & (w_grant == REQ0);
    assign ready1 = w_handshake & (w_grant == REQ1);

    assign w_sum = {1'b0, r_acc} + {1'b0, r_operand};
`ifdef ACCUM_SAT_EN
    assign w_acc_next = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_acc_next = w_sum[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_handshake) w_next_state = ST_ADD;
                ST_ADD:  w_next_state = ST_DONE;
                ST_DONE: w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_operand    <= '0;
            r_id         <= REQ0;
            r_last_grant <= REQ1;
            r_acc        <= '0;
            r_overflow   <= 1'b0;
            r_count      <= '0;
        end else if (clear) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else if (w_handshake) begin
            r_operand    <= (w_grant == REQ1) ? data1 : data0;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
        end else if (r_state == ST_ADD) begin
            r_acc      <= w_acc_next;
            r_overflow <= r_overflow | w_sum[WIDTH];
            r_count    <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign acc      = r_acc;
    assign overflow = r_overflow;
    assign op_count = r_count;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    // Gated so done_id never shows a stale ID outside the completion pulse.
    assign done_id  = done & r_id;

endmodule
`default_nettype wire
